// File: rtl/casex_prio_skid.sv
// Registered priority encoder of {src1[0],src2[0],src3[0]} behind a 2-entry skid buffer.
// Optional per-code saturating hit counters are built when CASEX_PRIO_STATS_EN is defined.
module casex_prio_skid #(
  parameter int size = 1,
  parameter int CNTW = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [size-1:0]   src1,
  input  logic [size-1:0]   src2,
  input  logic [size-1:0]   src3,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [size-1:0]   out_code,
  output logic [2:0]        out_lsbs,
  input  logic              clr_stats,
  output logic [4*CNTW-1:0] hits
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t      state;
  logic [2:0]  lsbs_in;
  logic [1:0]  code_in;
  logic [2:0]  head_lsbs_p0, skid_lsbs_p0;
  logic [1:0]  head_code_p0, skid_code_p0;
  logic        accept, pop;
  logic        unused_bits;

  function automatic logic [1:0] prio_code(input logic [2:0] l);
    logic [1:0] c;
    casez (l)
      3'b1??:  c = 2'd0;
      3'b01?:  c = 2'd1;
      3'b001:  c = 2'd2;
      3'b000:  c = 2'd3;
      default: c = 2'd3;
    endcase
    return c;
  endfunction

  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
    return (v == {CNTW{1'b1}}) ? v : v + CNTW'(1);
  endfunction

  assign lsbs_in     = {src1[0], src2[0], src3[0]};
  assign code_in     = prio_code(lsbs_in);
  assign unused_bits = ^{src1, src2, src3, clr_stats};

  assign in_ready  = (state != FULL) && !reset;
  assign out_valid = (state != EMPTY);
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_lsbs  = head_lsbs_p0;
  assign out_code  = size'(head_code_p0);

  // p0: head/skid registers; the skid slot only holds data while FULL
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= EMPTY;
      head_lsbs_p0 <= '0;
      head_code_p0 <= '0;
    end else begin
      case (state)
        EMPTY: if (accept) begin
          head_lsbs_p0 <= lsbs_in;
          head_code_p0 <= code_in;
          state        <= ONE;
        end
        ONE: begin
          if (accept && pop) begin
            head_lsbs_p0 <= lsbs_in;
            head_code_p0 <= code_in;
          end else if (accept) begin
            skid_lsbs_p0 <= lsbs_in;
            skid_code_p0 <= code_in;
            state        <= FULL;
          end else if (pop) begin
            state <= EMPTY;
          end
        end
        FULL: if (pop) begin
          head_lsbs_p0 <= skid_lsbs_p0;
          head_code_p0 <= skid_code_p0;
          state        <= ONE;
        end
        default: state <= EMPTY;
      endcase
    end
  end

`ifdef CASEX_PRIO_STATS_EN
  logic [CNTW-1:0] hit_p0 [4];

  // Clear dominates a coincident pop, so that pop goes uncounted
  always_ff @(posedge clk) begin
    if (reset || clr_stats) begin
      for (int i = 0; i < 4; i++) hit_p0[i] <= '0;
    end else if (pop) begin
      hit_p0[head_code_p0] <= sat_inc(hit_p0[head_code_p0]);
    end
  end

  assign hits = {hit_p0[3], hit_p0[2], hit_p0[1], hit_p0[0]};
`else
  assign hits = '0;
`endif

endmodule
